// File: rtl/seg7_pkg.sv
// Shared types and constants for the countdown timer / seven-segment display block.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [5:0] SEC_MAX   = 6'd59;

  // Two BCD digits {tens, ones} of a binary value 0..99
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes a slow square wave into clk and emits a one-cycle tick per rising edge.
// The tick is registered, so it appears SYNC_STAGES+1 cycles after the input rises.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/countdown_display_ctrl.sv
// MM:SS countdown timer with load/start/pause and a 4-digit multiplexed
// common-anode seven-segment driver. Optional macro BLINK_DONE_EN blinks the display in DONE.
module countdown_display_ctrl
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       clk_400Hz,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] set_min,
  input  logic [5:0] set_sec,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic       tick_1s;
  logic       tick_scan;
  state_e     state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [1:0] idx_q;
  logic [3:0] an_q;
  logic [6:0] seg_q;

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1s (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_1Hz),
    .tick     (tick_1s)
  );

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scan (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_400Hz),
    .tick     (tick_scan)
  );

  logic       count_zero;
  logic       last_sec;
  logic       load_ok;
  logic [6:0] ld_min;
  logic [5:0] ld_sec;

  assign count_zero = (min_q == 7'd0) && (sec_q == 6'd0);
  assign last_sec   = (min_q == 7'd0) && (sec_q == 6'd1);
  assign load_ok    = (state_q != RUN);
  assign ld_min     = (set_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : set_min;
  assign ld_sec     = (set_sec > SEC_MAX) ? SEC_MAX : set_sec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Priority load > pause > start > tick; load is simply not accepted in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!load && !pause && start && !count_zero) state_d = RUN;
      RUN: begin
        if (pause)                    state_d = PAUSED;
        else if (tick_1s && last_sec) state_d = DONE;
      end
      PAUSED:  if (!load && start && !pause) state_d = RUN;
      DONE:    if (load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
  end

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (load && load_ok) begin
      min_d = ld_min;
      sec_d = ld_sec;
    end else if (state_q == RUN && !pause && tick_1s) begin
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 7'd0) begin
        min_d = min_q - 7'd1;
        sec_d = SEC_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= 7'd0;
      sec_q <= 6'd0;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  logic [7:0] bcd_min;
  logic [7:0] bcd_sec;
  logic [3:0] cur_digit;

  assign bcd_min = bin2bcd(min_q);
  assign bcd_sec = bin2bcd({1'b0, sec_q});

  always_comb begin
    cur_digit = bcd_sec[3:0];
    case (idx_q)
      2'd0: cur_digit = bcd_sec[3:0];
      2'd1: cur_digit = bcd_sec[7:4];
      2'd2: cur_digit = bcd_min[3:0];
      2'd3: cur_digit = bcd_min[7:4];
      default: cur_digit = bcd_sec[3:0];
    endcase
  end

  // an and seg latch together from the current index, then the index advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else if (tick_scan) begin
      idx_q <= idx_q + 2'd1;
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= seg_of(cur_digit);
    end
  end

`ifdef BLINK_DONE_EN
  logic blink_q;

  always_ff @(posedge clk) begin
    if (rst)                              blink_q <= 1'b0;
    else if (state_d != DONE)             blink_q <= 1'b0;
    else if (state_q == DONE && tick_1s)  blink_q <= ~blink_q;
  end

  assign an = blink_q ? 4'b1111 : an_q;
`else
  assign an = an_q;
`endif

  assign seg = seg_q;

endmodule

// File: tb/tb_countdown_display_ctrl.sv
// Scoreboard bench: stimulus pushes expected scan outputs, a monitor pops on each anode change.
module tb_countdown_display_ctrl;

  localparam int SS   = 2;
  localparam int MAXM = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c1 = 1'b0, c400 = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [6:0] set_min = '0;
  logic [5:0] set_sec = '0;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;

  countdown_display_ctrl #(.SYNC_STAGES(SS), .MAX_MIN(MAXM)) dut (
    .clk(clk), .rst(rst), .clk_1Hz(c1), .clk_400Hz(c400),
    .load(load), .start(start), .pause(pause),
    .set_min(set_min), .set_sec(set_sec),
    .done(done), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tot = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_tot++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
  endtask

  // Reference model: count as total seconds, state as a small integer
  int m_total = 0, m_st = S_IDLE, m_idx = 0;

  function automatic void model(input bit l, input bit s, input bit p, input bit t,
                                input int mn, input int sc);
    if (m_st == S_RUN) begin
      if (p) m_st = S_PAUSED;
      else if (t && m_total > 0) begin
        m_total--;
        if (m_total == 0) m_st = S_DONE;
      end
    end else if (l) begin
      m_total = (mn > MAXM ? MAXM : mn) * 60 + (sc > 59 ? 59 : sc);
      if (m_st == S_DONE) m_st = S_IDLE;
    end else if (m_st != S_DONE && !p && s) begin
      if (m_st == S_PAUSED || m_total > 0) m_st = S_RUN;
    end
  endfunction

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       done;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  logic [3:0] an_prev = 4'b1111;

  always @(negedge clk) begin
    if (mon_en && an !== an_prev) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_scan: an=%b seg=%b with no expected entry", an, seg);
      end else begin
        mon_e = q.pop_front();
        chk("scan_an",      32'(an),   32'(mon_e.an));
        chk("scan_seg",     32'(seg),  32'(mon_e.seg));
        chk("scan_done",    32'(done), 32'(mon_e.done));
        chk("scan_latency", 32'(cyc),  32'(mon_e.due));
      end
    end
    an_prev = an;
  end

  task automatic ctrl(input bit l, input bit s, input bit p, input int mn, input int sc);
    @(negedge clk);
    load = l; start = s; pause = p;
    set_min = 7'(mn); set_sec = 6'(sc);
    model(l, s, p, 1'b0, mn, sc);
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sec_tick();
    @(negedge clk);
    c1 = 1'b1;
    model(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    repeat (SS + 4) @(negedge clk);
    c1 = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  // pause is held exactly on the cycle the synchronized 1 Hz tick is consumed
  task automatic pause_tick();
    @(negedge clk);
    c1 = 1'b1;
    repeat (SS + 1) @(negedge clk);
    pause = 1'b1;
    model(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    @(negedge clk);
    pause = 1'b0;
    repeat (SS + 2) @(negedge clk);
    c1 = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic scan();
    exp_t e;
    int mn, sc, d;
    mn = m_total / 60;
    sc = m_total % 60;
    case (m_idx)
      0: d = sc % 10;
      1: d = sc / 10;
      2: d = mn % 10;
      default: d = mn / 10;
    endcase
    e.an   = 4'b1111 ^ (4'b0001 << m_idx);
    e.seg  = seg_pat(d);
    e.done = (m_st == S_DONE);
    @(negedge clk);
    c400  = 1'b1;
    e.due = cyc + SS + 2;
    q.push_back(e);
    m_idx = (m_idx + 1) % 4;
    repeat (SS + 4) @(negedge clk);
    c400 = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic scan4();
    for (int i = 0; i < 4; i++) scan();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_an",   32'(an),   32'(4'b1111));
    chk("rst_seg",  32'(seg),  32'(7'b1111111));
    chk("rst_done", 32'(done), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    m_total = 0; m_st = S_IDLE; m_idx = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();

    // scan order and wrap on a zero count
    scan4();
    scan();

    ctrl(1, 0, 0, 1, 2);
    ctrl(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sec_tick();
      scan4();
    end

    // run down to DONE
    ctrl(0, 0, 1, 0, 0);
    ctrl(1, 0, 0, 0, 2);
    ctrl(0, 1, 0, 0, 0);
    sec_tick();
    sec_tick();
    @(negedge clk);
    chk("done_level", 32'(done), 32'(m_st == S_DONE));
    scan4();
    ctrl(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("done_start_ignored", 32'(done), 32'(m_st == S_DONE));

    // clamp, then load ignored in RUN
    ctrl(1, 0, 0, 120, 63);
    scan4();
    ctrl(0, 1, 0, 0, 0);
    ctrl(1, 0, 0, 3, 3);
    scan4();

    // pause on the tick cycle drops the tick
    pause_tick();
    scan4();
    ctrl(0, 1, 0, 0, 0);
    sec_tick();
    scan4();

    // reset mid-run at 05:30
    ctrl(0, 0, 1, 0, 0);
    ctrl(1, 0, 0, 5, 31);
    ctrl(0, 1, 0, 0, 0);
    sec_tick();
    scan4();
    do_reset();
    scan4();
    ctrl(0, 1, 0, 0, 0);
    sec_tick();
    scan4();

    for (int n = 0; n < 90; n++) begin
      case ($urandom_range(0, 9))
        0: ctrl(1, 0, 0, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 127) : $urandom_range(0, 1),
                $urandom_range(0, 63));
        1: ctrl(0, 1, 0, 0, 0);
        2: ctrl(0, 0, 1, 0, 0);
        3: ctrl(0, 1, 1, 0, 0);
        4: ctrl(1, 1, 0, 0, $urandom_range(0, 4));
        5, 6: sec_tick();
        7: pause_tick();
        default: scan();
      endcase
    end
    scan4();

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/countdown_display_ctrl.md
Name: countdown_display_ctrl

Overview:
- Consumer end of the divided-clock interface: takes the 1 Hz and 400 Hz square waves from the clock divider and converts them into single-cycle ticks in the `clk` domain.
- Runs an MM:SS countdown timer with load, start and pause control.
- Drives a 4-digit multiplexed seven-segment display, common anode, active-low.
- Sits between the clock divider and the board display pins.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per slow-clock input; legal values 2..3.
- MAX_MIN, 99: upper clamp for loaded minutes; legal values 1..99.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-high
- clk_1Hz  in  1  1 Hz square wave from divider; asynchronous to clk logic, sampled only
- clk_400Hz  in  1  400 Hz square wave from divider; sampled only
- load  in  1  level; loads set_min/set_sec when permitted
- start  in  1  level; begin or resume countdown
- pause  in  1  level; hold countdown
- set_min  in  7  binary minutes to load
- set_sec  in  6  binary seconds to load
- done  out  1  high while in DONE
- an  out  4  digit anodes, active-low, one-hot-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
Clock and reset:
- Single clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: state=IDLE, count=00:00, done=0, an=4'b1111, seg=7'b1111111, digit index=0, synchronizer and edge flops=0.

Tick generation:
- Each slow input passes through SYNC_STAGES flops, then a rising-edge detector.
- Produces tick_1s and tick_scan, each exactly 1 cycle wide.
- Latency: tick asserts SYNC_STAGES+1 clk cycles after the slow-clock rising edge.
- Falling edges produce nothing.

Count storage:
- Minutes and seconds held as binary: min 7 bits, sec 6 bits.
- Converted to BCD digits combinationally, MIN_TENS MIN_ONES SEC_TENS SEC_ONES, digits 3..0.

Load:
- Accepted only in IDLE, PAUSED or DONE. Ignored in RUN.
- Clamp: sec>59 loads 59; min>MAX_MIN loads MAX_MIN.
- Load in DONE goes to IDLE.

State machine (IDLE, RUN, PAUSED, DONE):
- IDLE: start && count!=0 -> RUN. start with count==0 stays IDLE.
- RUN: pause -> PAUSED. Otherwise, on tick_1s:
  - sec>0: sec-1.
  - sec==0 && min>0: min-1, sec=59.
  - A decrement that reaches 00:00 -> DONE in the same cycle.
- PAUSED: start && !pause -> RUN. Load permitted.
- DONE: done=1, count held at 00:00. load -> IDLE. start ignored.

Priority in a single cycle:
- load > pause > start > tick.
- pause coincident with tick_1s: tick dropped, count unchanged.
- start coincident with pause in IDLE/PAUSED: no transition.

Display scan:
- Digit index (2 bits) increments on each tick_scan and wraps 3->0. Each digit refreshes at 100 Hz.
- an: index 0 -> 4'b1110, ..., index 3 -> 4'b0111. Updates 1 cycle after tick_scan.
- seg: registered, updated in the same cycle as an, so the two never mismatch.
- Leading-zero blanking is not performed.

Reset mid-operation:
- Immediate return to the reset values on the next edge.
- In-flight ticks are discarded.

Optional Feature:
- Macro: BLINK_DONE_EN
- Defined: in DONE, a blink flag toggles on each tick_1s. While set, an=4'b1111, blanking the display. The flag clears on leaving DONE.
- Undefined: DONE shows static 0000. No blink flag is synthesized.

Decomposition:
- Package seg7_pkg:
  - state enum {IDLE, RUN, PAUSED, DONE}.
  - SEG_DIGIT[0:9] active-low patterns, e.g. 0=7'b1000000, 1=7'b1111001.
  - SEG_BLANK=7'b1111111.
  - SEC_MAX=59.
- Sub-module tick_sync (parameter SYNC_STAGES; in: clk, rst, async_in; out: tick). Instantiated twice.

Test Plan:
- Load set_min=1, set_sec=2, start, apply 3 tick_1s edges -> count reads 01:01, 01:00, 00:59.
- Load 0:02, start, 2 seconds -> DONE, done=1, seg on every digit = 7'b1000000. With BLINK_DONE_EN, an alternates 1111/scan per tick_1s.
- Load set_sec=63, set_min=120 -> count clamps to 99:59. Load asserted in RUN -> count unchanged.
- pause asserted on the same cycle as tick_1s in RUN -> PAUSED, count unchanged. start -> RUN, next tick decrements.
- 4 tick_scan edges -> an sequence 1110, 1101, 1011, 0111, then wraps to 1110. Each tick appears SYNC_STAGES+1 cycles after the clk_400Hz rising edge.
- rst pulsed mid-RUN at 05:30 -> next cycle IDLE, 00:00, an=1111, seg=1111111, done=0.
